// File: rtl/reverse_stream.sv
`default_nettype none
// ============================================================================
// Module   : reverse_stream
// Brief    : Streaming per-word bit/group reorder with a registered
//            valid/ready output and a 2-entry (OUT + SKID) buffer.
//            Optional macro REVERSE_CNT_EN adds the word_count port.
// Revision : 1.0 - initial release
// ============================================================================
module reverse_stream #(
    parameter int WIDTH = 100,
    parameter int GROUP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef REVERSE_CNT_EN
    ,
    output logic [15:0]      word_count
`endif
);

    localparam int c_num_groups = WIDTH / GROUP;

    if (WIDTH < 2) begin : g_bad_width
        $error("reverse_stream: WIDTH must be >= 2");
    end
    if (GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_bad_group
        $error("reverse_stream: WIDTH must be a multiple of GROUP");
    end

    // Reset asserts asynchronously and releases on a clock edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    logic [WIDTH-1:0] w_bit_rev;
    logic [WIDTH-1:0] w_grp_rev;
    logic [WIDTH-1:0] w_in_grp_rev;
    logic [WIDTH-1:0] w_reord;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit_rev
        assign w_bit_rev[i] = in_data[WIDTH-1-i];
    end

    for (genvar k = 0; k < c_num_groups; k++) begin : g_grp
        for (genvar j = 0; j < GROUP; j++) begin : g_bit
            assign w_grp_rev[k*GROUP+j]    = in_data[(c_num_groups-1-k)*GROUP+j];
            assign w_in_grp_rev[k*GROUP+j] = in_data[k*GROUP+GROUP-1-j];
        end
    end

    always_comb begin
        w_reord = in_data;
        case (in_mode)
            2'd0:    w_reord = in_data;
            2'd1:    w_reord = w_bit_rev;
            2'd2:    w_reord = w_grp_rev;
            default: w_reord = w_in_grp_rev;
        endcase
    end

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_in_fire;
    logic             w_out_fire;

    assign in_ready   = !r_skid_valid;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign w_in_fire  = in_valid && !r_skid_valid;
    assign w_out_fire = r_out_valid && out_ready;

    // (skid_valid, out_valid) encodes EMPTY / ONE / FULL; SKID holds reordered data.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (!r_out_valid) begin
            if (w_in_fire) begin
                r_out_data  <= w_reord;
                r_out_valid <= 1'b1;
            end
        end else if (!r_skid_valid) begin
            if (w_in_fire && w_out_fire) begin
                r_out_data <= w_reord;
            end else if (w_in_fire) begin
                r_skid_data  <= w_reord;
                r_skid_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end else if (w_out_fire) begin
            r_out_data   <= r_skid_data;
            r_skid_valid <= 1'b0;
        end
    end

`ifdef REVERSE_CNT_EN
    logic [15:0] r_word_count;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_word_count <= 16'd0;
        end else if (w_out_fire && r_word_count != 16'hFFFF) begin
            r_word_count <= r_word_count + 16'd1;
        end
    end

    assign word_count = r_word_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reverse_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_reverse_stream
// Brief    : Self-checking bench for reverse_stream (WIDTH=10, GROUP=2) with a
//            queue-based reference model and directed + random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reverse_stream;

    localparam int W = 10;
    localparam int G = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [1:0]   in_mode = 2'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
`ifdef REVERSE_CNT_EN
    logic [15:0]  word_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;

    logic [W-1:0] q[$];
    logic         stall = 1'b0;
    logic [W-1:0] stall_data = '0;

    reverse_stream #(.WIDTH(W), .GROUP(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef REVERSE_CNT_EN
        ,
        .word_count(word_count)
`endif
    );

    always #5 clk = ~clk;

    // Mode 3 is a full reverse followed by a group-order reverse.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [1:0] m);
        logic [W-1:0] r;
        logic [W-1:0] mask;
        r    = '0;
        mask = W'((1 << G) - 1);
        case (m)
            2'd0: r = d;
            2'd1: for (int i = 0; i < W; i++) r[i] = d[W-1-i];
            2'd2: for (int k = 0; k < W/G; k++)
                      r = r | (((d >> ((W/G-1-k)*G)) & mask) << (k*G));
            default: r = model(model(d, 2'd1), 2'd2);
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [1:0] m);
        int b;
        b        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        @(negedge clk);
        while (!in_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard: handshakes are sampled mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            stall <= 1'b0;
        end else begin
            if (stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(stall_data));
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_data, in_mode));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    check("stream_data", 32'(out_data), 32'(q.pop_front()));
                end
            end
            stall      <= out_valid && !out_ready;
            stall_data <= out_data;
        end
    end

    initial begin
        int cyc;

        // Reset state
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef REVERSE_CNT_EN
        check("rst_word_count", 32'(word_count), 32'd0);
`endif
        repeat (3) tick();

        // Model pinned to hand-computed values
        check("model_m1", 32'(model(10'b1110101010, 2'd1)), 32'(10'b0101010111));
        check("model_m2", 32'(model(10'b1110101010, 2'd2)), 32'(10'b1010101011));
        check("model_m3", 32'(model(10'b1110101010, 2'd3)), 32'(10'b1101010101));

        // Single-cycle latency and each mode
        out_ready = 1'b1;
        send(10'b1110101010, 2'd1);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("m1_a", 32'(out_data), 32'(10'b0101010111));
        send(10'b0101010111, 2'd1);
        check("m1_b", 32'(out_data), 32'(10'b1110101010));
        send(10'b1110101010, 2'd2);
        check("m2", 32'(out_data), 32'(10'b1010101011));
        send(10'b1110101010, 2'd3);
        check("m3", 32'(out_data), 32'(10'b1101010101));
        send(10'b1110101010, 2'd0);
        check("m0", 32'(out_data), 32'(10'b1110101010));
        tick();
        tick();
        check("drained", 32'(out_valid), 32'd0);

        // Back-pressure fills OUT then SKID
        out_ready = 1'b0;
        send(10'h155, 2'd0);
        send(10'h2AA, 2'd0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_a", 32'(out_data), 32'h155);
        tick();
        check("hold_out_a", 32'(out_data), 32'h155);
        out_ready = 1'b1;
        tick();
        check("skid_to_out_b", 32'(out_data), 32'h2AA);
        check("ready_again", 32'(in_ready), 32'd1);
        tick();
        check("empty_after_b", 32'(out_valid), 32'd0);

        // Random traffic
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 1000 && cyc < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            in_mode   = 2'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc       = 0;
        while ((q.size() != 0 || out_valid) && cyc < 100) begin
            tick();
            cyc++;
        end
        check("random_accepted", 32'(n_acc >= 1000), 32'd1);
        check("random_drained", 32'(q.size()), 32'd0);

        // Reset while FULL discards both words immediately
        out_ready = 1'b0;
        send(10'h0F0, 2'd1);
        send(10'h30C, 2'd2);
        check("pre_rst_full", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_in_ready", 32'(in_ready), 32'd1);
        check("async_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        check("post_rst_empty", 32'(out_valid), 32'd0);

`ifdef REVERSE_CNT_EN
        in_valid = 1'b1;
        in_mode  = 2'd0;
        repeat (70000) tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("count_saturate", 32'(word_count), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
